// File: rtl/riscv_pkg.sv
// Shared constants and loader state encoding for the instruction-memory
// boot loader and the instruction memory itself.
package riscv_pkg;

  localparam int unsigned IMEM_BYTES  = 1024;
  localparam int unsigned IMEM_ADDR_W = 10;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_RECV,
    LD_WR0,
    LD_WR1,
    LD_WR2,
    LD_WR3,
    LD_DONE,
    LD_ERROR
  } loader_state_t;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Host-to-loader word stream: valid/ready handshake carrying one 32-bit
// instruction word per transfer.
interface imem_boot_loader_if;

  logic        word_valid;
  logic [31:0] word_data;
  logic        word_ready;

  modport master (output word_valid, output word_data, input word_ready);
  modport slave  (input word_valid, input word_data, output word_ready);

endinterface

// File: rtl/imem_byte_serializer.sv
// Splits one 32-bit word into four consecutive little-endian byte writes
// with registered memory-port outputs; done marks the final byte.
module imem_byte_serializer
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W     = IMEM_ADDR_W,
  parameter int unsigned RESET_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [31:0]       word,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              done
);

  logic [23:0] rest;
  logic [1:0]  idx;

  // Byte 0 is loaded on the accept edge so it is on the port in WR0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= ADDR_W'(RESET_ADDR);
      mem_wdata <= '0;
      rest      <= '0;
      idx       <= '0;
    end else if (start) begin
      mem_we    <= 1'b1;
      mem_addr  <= start_addr;
      mem_wdata <= word[7:0];
      rest      <= word[31:8];
      idx       <= '0;
    end else if (mem_we) begin
      if (idx == 2'd3) begin
        mem_we <= 1'b0;
      end else begin
        idx       <= idx + 2'd1;
        mem_addr  <= mem_addr + ADDR_W'(1);
        mem_wdata <= rest[7:0];
        rest      <= {8'h00, rest[23:8]};
      end
    end
  end

  assign done = mem_we && (idx == 2'd3);

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a program into byte-addressed instruction memory from a word stream
// and holds the core in reset until the load completes successfully.
module imem_boot_loader
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W    = IMEM_ADDR_W,
  parameter int unsigned MEM_BYTES = IMEM_BYTES,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned CNT_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [CNT_W-1:0]  num_words,
  imem_boot_loader_if.slave host,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              core_hold,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_error
);

  localparam int unsigned AW1 = ADDR_W + 1;

  loader_state_t    state, state_nxt;
  logic [CNT_W-1:0] words_left;
  logic [AW1-1:0]   next_addr;
  logic [AW1-1:0]   addr_end;
  logic             overflow;
  logic             ser_start;
  logic             ser_done;
  logic             do_load;
  logic             word_done;

  // One extra address bit keeps the end-of-word compare from wrapping.
  assign addr_end = next_addr + AW1'(4);
  assign overflow = addr_end > AW1'(MEM_BYTES);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LD_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ser_start = 1'b0;
    do_load   = 1'b0;
    word_done = 1'b0;
    case (state)
      LD_IDLE, LD_DONE, LD_ERROR: begin
        if (load_start) begin
          do_load   = 1'b1;
          state_nxt = (num_words == '0) ? LD_DONE : LD_RECV;
        end
      end
      LD_RECV: begin
        if (host.word_valid) begin
          if (overflow) begin
            state_nxt = LD_ERROR;
          end else begin
            ser_start = 1'b1;
            state_nxt = LD_WR0;
          end
        end
      end
      LD_WR0: state_nxt = LD_WR1;
      LD_WR1: state_nxt = LD_WR2;
      LD_WR2: state_nxt = LD_WR3;
      LD_WR3: begin
        if (ser_done) begin
          word_done = 1'b1;
          state_nxt = (words_left == CNT_W'(1)) ? LD_DONE : LD_RECV;
        end
      end
      default: state_nxt = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      words_left <= '0;
      next_addr  <= AW1'(BASE_ADDR);
    end else if (do_load) begin
      words_left <= num_words;
      next_addr  <= AW1'(BASE_ADDR);
    end else if (word_done) begin
      words_left <= words_left - CNT_W'(1);
      next_addr  <= next_addr + AW1'(4);
    end
  end

  imem_byte_serializer #(
    .ADDR_W     (ADDR_W),
    .RESET_ADDR (BASE_ADDR)
  ) u_ser (
    .clk        (clk),
    .reset      (reset),
    .start      (ser_start),
    .start_addr (next_addr[ADDR_W-1:0]),
    .word       (host.word_data),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .done       (ser_done)
  );

  assign host.word_ready = (state == LD_RECV);
  assign load_busy       = (state == LD_RECV) || (state == LD_WR0) || (state == LD_WR1) ||
                           (state == LD_WR2)  || (state == LD_WR3);
  assign core_hold       = (state != LD_DONE);
  assign load_done       = (state == LD_DONE);
  assign load_error      = (state == LD_ERROR);

endmodule
